// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM memory arbiter.
package mem_arb_pkg;

   localparam int ARB_ADDR_W      = 32;
   localparam int ARB_DATA_W      = 32;
   localparam int ARB_BE_W        = ARB_DATA_W / 8;
   localparam int ARB_TIMEOUT_DEF = 64;

   // One transaction in flight at a time; REQ states drive the bus, RESP states wait.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_IF_REQ  = 3'd1,
      ST_IF_RESP = 3'd2,
      ST_DM_REQ  = 3'd3,
      ST_DM_RESP = 3'd4
   } arb_state_e;

   // Request captured on entry to a REQ state and held until the grant.
   typedef struct packed {
      logic                  we;
      logic [ARB_BE_W-1:0]   be;
      logic [ARB_ADDR_W-1:0] addr;
      logic [ARB_DATA_W-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/arb_timeout_counter.sv
// Counts cycles spent waiting for rvalid; hit is asserted once the count reaches TIMEOUT.
module arb_timeout_counter
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic hit
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] count_r;

   // Wait counter: cleared on grant, advances in RESP, saturates at TIMEOUT.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= '0;
      end else if (clr) begin
         count_r <= '0;
      end else if (en && !hit) begin
         count_r <= count_r + CNT_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign hit = (count_r == CNT_W'(TIMEOUT));

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one handshaked single-port memory between instruction fetch and load/store.
// Data port has fixed priority; flushed fetch responses are silently dropped.
module imem_dmem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = ARB_ADDR_W,
   parameter int DATA_W  = ARB_DATA_W,
   parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                if_req_i,
   input  logic [ADDR_W-1:0]   if_addr_i,
   output logic                if_ack_o,
   output logic [DATA_W-1:0]   if_rdata_o,
   input  logic                dm_req_i,
   input  logic                dm_we_i,
   input  logic [DATA_W/8-1:0] dm_be_i,
   input  logic [ADDR_W-1:0]   dm_addr_i,
   input  logic [DATA_W-1:0]   dm_wdata_i,
   output logic                dm_ack_o,
   output logic [DATA_W-1:0]   dm_rdata_o,
   input  logic                flush_i,
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [DATA_W/8-1:0] mem_be_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   input  logic                mem_gnt_i,
   input  logic                mem_rvalid_i,
   input  logic [DATA_W-1:0]   mem_rdata_i,
   output logic                stall_if_o,
   output logic                stall_mem_o,
   output logic                err_o
);

   // The request register is a package struct, so its field widths come from the package.
   localparam int BE_W = DATA_W / 8;

   arb_state_e        state_r, state_s;
   mem_req_t          req_r, req_s;
   logic              drop_r, drop_s;
   logic              if_ack_r, if_ack_s;
   logic              dm_ack_r, dm_ack_s;
   logic              err_r, err_s;
   logic [DATA_W-1:0] if_rdata_r, if_rdata_s;
   logic [DATA_W-1:0] dm_rdata_r, dm_rdata_s;
   logic              timer_clr_s, timer_en_s, timer_hit_s;

   arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk (clk_i),
      .rst (rst_i),
      .clr (timer_clr_s),
      .en  (timer_en_s),
      .hit (timer_hit_s)
   );

   // FSM state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state, request capture, drop tracking and response decode.
   always_comb begin
      state_s     = state_r;
      req_s       = req_r;
      drop_s      = drop_r;
      if_ack_s    = 1'b0;
      dm_ack_s    = 1'b0;
      err_s       = 1'b0;
      if_rdata_s  = if_rdata_r;
      dm_rdata_s  = dm_rdata_r;
      timer_clr_s = 1'b0;
      timer_en_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // A port in its ack cycle is not re-granted: its req is still the old one.
            if (dm_req_i && !dm_ack_r) begin
               state_s     = ST_DM_REQ;
               req_s.we    = dm_we_i;
               req_s.be    = dm_be_i;
               req_s.addr  = dm_addr_i;
               req_s.wdata = dm_wdata_i;
            end else if (if_req_i && !if_ack_r) begin
               state_s     = ST_IF_REQ;
               req_s.we    = 1'b0;
               req_s.be    = {BE_W{1'b1}};
               req_s.addr  = if_addr_i;
               req_s.wdata = {DATA_W{1'b0}};
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_IF_REQ: begin
            if (flush_i) begin
               drop_s = 1'b1;
            end else begin
               drop_s = drop_r;
            end
            if (mem_gnt_i) begin
               state_s     = ST_IF_RESP;
               timer_clr_s = 1'b1;
            end else begin
               state_s = ST_IF_REQ;
            end
         end
         ST_IF_RESP: begin
            timer_en_s = 1'b1;
            if (mem_rvalid_i) begin
               state_s = ST_IDLE;
               drop_s  = 1'b0;
               // A flush arriving with the response still kills it.
               if (drop_r || flush_i) begin
                  if_ack_s = 1'b0;
               end else begin
                  if_ack_s   = 1'b1;
                  if_rdata_s = mem_rdata_i;
               end
            end else if (timer_hit_s) begin
               state_s = ST_IDLE;
               err_s   = 1'b1;
               drop_s  = 1'b0;
            end else if (flush_i) begin
               drop_s = 1'b1;
            end else begin
               drop_s = drop_r;
            end
         end
         ST_DM_REQ: begin
            if (mem_gnt_i) begin
               state_s     = ST_DM_RESP;
               timer_clr_s = 1'b1;
            end else begin
               state_s = ST_DM_REQ;
            end
         end
         ST_DM_RESP: begin
            timer_en_s = 1'b1;
            if (mem_rvalid_i) begin
               state_s  = ST_IDLE;
               dm_ack_s = 1'b1;
               if (req_r.we) begin
                  dm_rdata_s = {DATA_W{1'b0}};
               end else begin
                  dm_rdata_s = mem_rdata_i;
               end
            end else if (timer_hit_s) begin
               state_s = ST_IDLE;
               err_s   = 1'b1;
            end else begin
               state_s = ST_DM_RESP;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Registered request, drop flag and requester-facing outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         req_r      <= '0;
         drop_r     <= 1'b0;
         if_ack_r   <= 1'b0;
         dm_ack_r   <= 1'b0;
         err_r      <= 1'b0;
         if_rdata_r <= {DATA_W{1'b0}};
         dm_rdata_r <= {DATA_W{1'b0}};
      end else begin
         req_r      <= req_s;
         drop_r     <= drop_s;
         if_ack_r   <= if_ack_s;
         dm_ack_r   <= dm_ack_s;
         err_r      <= err_s;
         if_rdata_r <= if_rdata_s;
         dm_rdata_r <= dm_rdata_s;
      end
   end

   assign mem_req_o   = (state_r == ST_IF_REQ) || (state_r == ST_DM_REQ);
   assign mem_we_o    = req_r.we;
   assign mem_be_o    = req_r.be;
   assign mem_addr_o  = req_r.addr;
   assign mem_wdata_o = req_r.wdata;
   assign if_ack_o    = if_ack_r;
   assign dm_ack_o    = dm_ack_r;
   assign if_rdata_o  = if_rdata_r;
   assign dm_rdata_o  = dm_rdata_r;
   assign err_o       = err_r;
   assign stall_if_o  = if_req_i & ~if_ack_r;
   assign stall_mem_o = dm_req_i & ~dm_ack_r;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench for imem_dmem_arbiter: memory responder model plus response scoreboard.
module tb_imem_dmem_arbiter;

   localparam int TO = 64;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        if_req_i = 1'b0;
   logic [31:0] if_addr_i = 32'h0;
   logic        if_ack_o;
   logic [31:0] if_rdata_o;
   logic        dm_req_i = 1'b0;
   logic        dm_we_i = 1'b0;
   logic [3:0]  dm_be_i = 4'h0;
   logic [31:0] dm_addr_i = 32'h0;
   logic [31:0] dm_wdata_i = 32'h0;
   logic        dm_ack_o;
   logic [31:0] dm_rdata_o;
   logic        flush_i = 1'b0;
   logic        mem_req_o, mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_gnt_i = 1'b0;
   logic        mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = 32'h0;
   logic        stall_if_o, stall_mem_o, err_o;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;

   typedef struct {
      bit          dm;
      logic [31:0] data;
   } exp_t;
   exp_t exp_q[$];

   // Memory model state
   logic [31:0] mem_arr [logic [31:0]];
   int          gnt_wait = 0;
   int          rv_wait = 0;
   bit          no_resp = 1'b0;
   bit          resp_pending = 1'b0;
   int          rv_left = 0;
   int          gnt_left = -1;
   logic [31:0] resp_data = 32'h0;

   imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i), .dm_addr_i(dm_addr_i),
      .dm_wdata_i(dm_wdata_i), .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
      .flush_i(flush_i),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i),
      .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (mem_arr.exists(a)) return mem_arr[a];
      return a ^ 32'hA5A5_0000;
   endfunction

   // Memory responder: grant after gnt_wait cycles, rvalid rv_wait cycles after the grant cycle + 1.
   initial begin
      forever begin
         logic [31:0] cur;
         @(posedge clk);
         #1;
         mem_gnt_i    = 1'b0;
         mem_rvalid_i = 1'b0;
         mem_rdata_i  = 32'hBAD0_0BAD;
         if (resp_pending) begin
            if (rv_left == 0) begin
               mem_rvalid_i = 1'b1;
               mem_rdata_i  = resp_data;
               resp_pending = 1'b0;
            end else begin
               rv_left = rv_left - 1;
            end
         end else if (mem_req_o) begin
            if (gnt_left < 0) gnt_left = gnt_wait;
            if (gnt_left == 0) begin
               mem_gnt_i = 1'b1;
               gnt_left  = -1;
               if (mem_we_o) begin
                  cur = mem_read(mem_addr_o);
                  for (int b = 0; b < 4; b++)
                     if (mem_be_o[b]) cur[8*b +: 8] = mem_wdata_o[8*b +: 8];
                  mem_arr[mem_addr_o] = cur;
                  resp_data = 32'hFFFF_FFFF;
               end else begin
                  resp_data = mem_read(mem_addr_o);
               end
               resp_pending = !no_resp;
               rv_left      = rv_wait;
            end else begin
               gnt_left = gnt_left - 1;
            end
         end
      end
   end

   // Waits (bounded) for an ack on one port; returns at the negedge of the ack cycle.
   task automatic wait_ack(input bit dm, input int budget, output bit seen, output logic [31:0] data);
      seen = 1'b0;
      data = 32'h0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (dm ? dm_ack_o : if_ack_o) begin
            seen = 1'b1;
            data = dm ? dm_rdata_o : if_rdata_o;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_i = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({mem_req_o, if_ack_o, dm_ack_o, err_o, mem_we_o} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got req/ifack/dmack/err/we=%b expected 00000",
                  {mem_req_o, if_ack_o, dm_ack_o, err_o, mem_we_o});
      end
      n_checks++;
      if ({if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o, mem_be_o} !== 132'h0) begin
         n_fail++;
         $display("FAIL reset_data: got if_rdata=%h dm_rdata=%h addr=%h wdata=%h be=%h expected all 0",
                  if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o, mem_be_o);
      end
      rst_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_read_fetch;
      exp_t e;
      if_addr_i = 32'h0000_0010;
      if_req_i  = 1'b1;
      exp_q.push_back('{dm: 1'b0, data: 32'h0051_0093});
      #1;
      n_checks++;
      if (stall_if_o !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_c0: got %b expected 1", stall_if_o); end
      @(negedge clk);
      n_checks++;
      if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h10}) begin
         n_fail++;
         $display("FAIL fetch_issue_c1: got req=%b we=%b be=%h addr=%h expected 1 0 f 00000010",
                  mem_req_o, mem_we_o, mem_be_o, mem_addr_o);
      end
      @(negedge clk);
      n_checks++;
      if ({mem_req_o, if_ack_o, stall_if_o} !== 3'b001) begin
         n_fail++;
         $display("FAIL fetch_wait_c2: got req/ack/stall=%b expected 001", {mem_req_o, if_ack_o, stall_if_o});
      end
      @(negedge clk);
      n_checks++;
      if ({if_ack_o, stall_if_o} !== 2'b10) begin
         n_fail++;
         $display("FAIL fetch_ack_c3: got ack/stall=%b expected 10", {if_ack_o, stall_if_o});
      end
      if (if_ack_o === 1'b1) begin
         e = exp_q.pop_front();
         n_checks++;
         if (if_rdata_o !== e.data) begin
            n_fail++;
            $display("FAIL fetch_rdata: got %h expected %h", if_rdata_o, e.data);
         end
      end
      if_req_i = 1'b0;
      @(negedge clk);
      n_checks++;
      if (if_ack_o !== 1'b0) begin n_fail++; $display("FAIL fetch_ack_pulse: got %b expected 0", if_ack_o); end
   endtask

   task automatic test_collision;
      exp_t e;
      bit dm_done = 1'b0, if_done = 1'b0;
      int dm_ack_cyc = -1, fetch_cyc = -1;
      dm_addr_i = 32'h100; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_req_i = 1'b1;
      if_addr_i = 32'h44;  if_req_i = 1'b1;
      exp_q.push_back('{dm: 1'b1, data: 32'h1234_5678});
      exp_q.push_back('{dm: 1'b0, data: 32'h0000_0013});
      @(negedge clk);
      n_checks++;
      if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h100}) begin
         n_fail++;
         $display("FAIL coll_first: got req=%b addr=%h expected 1 00000100", mem_req_o, mem_addr_o);
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (dm_ack_o) begin
            e = exp_q.pop_front();
            n_checks++;
            if (!e.dm || dm_rdata_o !== e.data) begin
               n_fail++;
               $display("FAIL coll_dm_rdata: got %h expected %h (dm=%0d)", dm_rdata_o, e.data, e.dm);
            end
            dm_req_i = 1'b0; dm_done = 1'b1; dm_ack_cyc = cyc;
         end
         if (mem_req_o && mem_addr_o == 32'h44 && fetch_cyc < 0) begin
            fetch_cyc = cyc;
            n_checks++;
            if (!dm_done) begin n_fail++; $display("FAIL coll_order: got fetch issued before dm_ack expected after"); end
         end
         if (if_ack_o) begin
            e = exp_q.pop_front();
            n_checks++;
            if (e.dm || if_rdata_o !== e.data) begin
               n_fail++;
               $display("FAIL coll_if_rdata: got %h expected %h (dm=%0d)", if_rdata_o, e.data, e.dm);
            end
            if_req_i = 1'b0; if_done = 1'b1;
            break;
         end else begin
            n_checks++;
            if (stall_if_o !== 1'b1) begin n_fail++; $display("FAIL coll_stall_if: got %b expected 1", stall_if_o); end
         end
      end
      n_checks++;
      if (!if_done || fetch_cyc != dm_ack_cyc + 1) begin
         n_fail++;
         $display("FAIL coll_reissue: got fetch cycle %0d (acked %0d) expected dm_ack cycle %0d + 1",
                  fetch_cyc, if_done, dm_ack_cyc);
      end
      @(negedge clk);
   endtask

   task automatic test_store;
      exp_t e;
      bit seen;
      logic [31:0] d;
      dm_addr_i = 32'h200; dm_we_i = 1'b1; dm_be_i = 4'b0011; dm_wdata_i = 32'hDEAD_BEEF; dm_req_i = 1'b1;
      exp_q.push_back('{dm: 1'b1, data: 32'h0});
      @(negedge clk);
      n_checks++;
      if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b1, 4'b0011, 32'h200, 32'hDEAD_BEEF}) begin
         n_fail++;
         $display("FAIL store_issue: got req=%b we=%b be=%b addr=%h wdata=%h expected 1 1 0011 00000200 deadbeef",
                  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
      end
      wait_ack(1'b1, 10, seen, d);
      e = exp_q.pop_front();
      n_checks++;
      if (!seen || d !== e.data) begin
         n_fail++;
         $display("FAIL store_ack: got seen=%0d rdata=%h expected 1 %h", seen, d, e.data);
      end
      dm_req_i = 1'b0; dm_we_i = 1'b0;
      @(negedge clk);
      dm_be_i = 4'hF; dm_req_i = 1'b1;
      exp_q.push_back('{dm: 1'b1, data: 32'h1111_BEEF});
      wait_ack(1'b1, 10, seen, d);
      e = exp_q.pop_front();
      n_checks++;
      if (!seen || d !== e.data) begin
         n_fail++;
         $display("FAIL store_readback: got seen=%0d rdata=%h expected 1 %h", seen, d, e.data);
      end
      dm_req_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_flush;
      exp_t e;
      bit seen;
      logic [31:0] d;
      rv_wait = 2;
      if_addr_i = 32'h80; if_req_i = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h80}) begin
         n_fail++;
         $display("FAIL flush_issue: got req=%b addr=%h expected 1 00000080", mem_req_o, mem_addr_o);
      end
      @(negedge clk);
      @(negedge clk);
      flush_i = 1'b1; if_addr_i = 32'h40; rv_wait = 0;
      @(negedge clk);
      flush_i = 1'b0;
      @(negedge clk);
      n_checks++;
      if (if_ack_o !== 1'b0 || if_rdata_o !== 32'h0000_0013) begin
         n_fail++;
         $display("FAIL flush_drop: got ack=%b rdata=%h expected 0 00000013", if_ack_o, if_rdata_o);
      end
      exp_q.push_back('{dm: 1'b0, data: 32'h0040_0113});
      wait_ack(1'b0, 20, seen, d);
      e = exp_q.pop_front();
      n_checks++;
      if (!seen || d !== e.data) begin
         n_fail++;
         $display("FAIL flush_refetch: got seen=%0d rdata=%h expected 1 %h", seen, d, e.data);
      end
      if_req_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_timeout;
      int grant_cyc = 0, err_cyc = -1, errs = 0;
      gnt_wait = 5; no_resp = 1'b1;
      dm_addr_i = 32'h300; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_req_i = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         n_checks++;
         if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h300}) begin
            n_fail++;
            $display("FAIL gnt_stall_stable c%0d: got req=%b addr=%h expected 1 00000300", i, mem_req_o, mem_addr_o);
         end
         grant_cyc = cyc;
      end
      gnt_wait = 0;
      for (int i = 0; i < TO + 20; i++) begin
         @(negedge clk);
         if (dm_ack_o) begin n_fail++; n_checks++; $display("FAIL timeout_ack: got dm_ack=1 expected 0"); end
         if (err_o) begin
            errs++;
            if (err_cyc < 0) begin
               err_cyc = cyc;
               n_checks++;
               if ({mem_req_o, stall_mem_o} !== 2'b01) begin
                  n_fail++;
                  $display("FAIL timeout_state: got req/stall_mem=%b expected 01", {mem_req_o, stall_mem_o});
               end
               dm_req_i = 1'b0;
            end
         end else if (err_cyc >= 0) begin
            n_checks++;
            if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: got mem_req=%b expected 0", mem_req_o); end
         end
      end
      n_checks++;
      if (errs != 1 || err_cyc - grant_cyc < TO + 1 || err_cyc - grant_cyc > TO + 3) begin
         n_fail++;
         $display("FAIL timeout_err: got %0d pulses, %0d cycles after grant expected 1 pulse, %0d..%0d cycles",
                  errs, err_cyc - grant_cyc, TO + 1, TO + 3);
      end
      no_resp = 1'b0;
   endtask

   task automatic test_reset_mid;
      exp_t e;
      bit done = 1'b0;
      rv_wait = 3;
      dm_addr_i = 32'h400; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_req_i = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h400}) begin
         n_fail++;
         $display("FAIL rstmid_issue: got req=%b addr=%h expected 1 00000400", mem_req_o, mem_addr_o);
      end
      @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0; dm_req_i = 1'b0;
      n_checks++;
      if ({mem_req_o, dm_ack_o, if_ack_o, err_o} !== 4'b0) begin
         n_fail++;
         $display("FAIL rstmid_outputs: got req/dmack/ifack/err=%b expected 0000", {mem_req_o, dm_ack_o, if_ack_o, err_o});
      end
      @(negedge clk);
      rv_wait = 0;
      if_addr_i = 32'h10; if_req_i = 1'b1;
      exp_q.push_back('{dm: 1'b0, data: 32'h0051_0093});
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (dm_ack_o) begin n_fail++; n_checks++; $display("FAIL rstmid_late_ack: got dm_ack=1 expected 0"); end
         if (if_ack_o) begin
            e = exp_q.pop_front();
            n_checks++;
            if (if_rdata_o !== e.data) begin
               n_fail++;
               $display("FAIL rstmid_fetch: got %h expected %h", if_rdata_o, e.data);
            end
            done = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!done) begin n_fail++; $display("FAIL rstmid_fetch_done: got no if_ack expected one"); end
      if_req_i = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      mem_arr[32'h10]  = 32'h0051_0093;
      mem_arr[32'h44]  = 32'h0000_0013;
      mem_arr[32'h100] = 32'h1234_5678;
      mem_arr[32'h200] = 32'h1111_1111;
      mem_arr[32'h80]  = 32'hAAAA_0001;
      mem_arr[32'h40]  = 32'h0040_0113;
      test_reset();
      test_read_fetch();
      test_collision();
      test_store();
      test_flush();
      test_timeout();
      test_reset_mid();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: got %0d entries left expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
